// File: rtl/acq_seq_pkg.sv
// Shared definitions for the rangefinder acquisition sequencer.
package acq_seq_pkg;

  localparam int NBANKS = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TRIG = 3'd1,
    S_FILL = 3'd2,
    S_XREQ = 3'd3,
    S_XFER = 3'd4,
    S_DONE = 3'd5,
    S_WAIT = 3'd6
  } acq_state_e;

endpackage

// File: rtl/acq_fill_timer.sv
// FILL-phase timeout: down-counter loaded on clear, expire at terminal count zero.
module acq_fill_timer
  import acq_seq_pkg::*;
#(
  parameter int TMO_W   = 16,
  parameter int TMO_CYC = 60000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TMO_W-1:0] LOAD = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= LOAD;
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  // Counter reads TMO_CYC-1-k in the k-th FILL cycle, so zero marks the last allowed cycle.
  assign expire = (count_q == '0);

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: laser trigger, FIFO fill gating, DMA kick and ping-pong bank handoff.
//
// state | meaning
// IDLE  | no run in progress, waiting for cmd_start
// TRIG  | laser fired this cycle, capture enabled, timer cleared
// FILL  | capturing into FIFO until threshold or timeout
// XREQ  | waiting for DMA idle, then issue dma_start
// XFER  | DMA moving FIFO into RAM bank bank_sel
// DONE  | mark bank full, count shot, pick next bank
// WAIT  | next bank still owned by CPU, capture held off
module acq_sequencer
  import acq_seq_pkg::*;
#(
  parameter int LVL_W   = 8,
  parameter int TMO_W   = 16,
  parameter int TMO_CYC = 60000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_enable,
  input  logic [LVL_W-1:0]  cfg_threshold,
  input  logic [LVL_W-1:0]  cfg_nshots,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic [NBANKS-1:0] bank_release,
  input  logic [LVL_W-1:0]  fifo_usdw,
  input  logic              dma_busy,
  input  logic              dma_ready,
  output logic              dma_start,
  output logic              laser_trig,
  output logic              capture_en,
  output logic              bank_sel,
  output logic [NBANKS-1:0] bank_full,
  output logic [LVL_W-1:0]  shot_cnt,
  output logic              run_busy,
  output logic              timeout_flag,
  output logic              irq
);

  acq_state_e state_q, state_d;

  logic [LVL_W-1:0]  nshots_q, thr_q, shot_cnt_q, shot_inc;
  logic [NBANKS-1:0] bank_full_q, set_mask;
  logic              bank_sel_q, timeout_q, abort_pend_q;
  logic              laser_trig_q, capture_en_q, dma_start_q, run_busy_q;

  logic latch_cfg, set_full, toggle_bank, set_tmo, start_dma;
  logic timer_clr, timer_en, timer_exp;

  acq_fill_timer #(
    .TMO_W   (TMO_W),
    .TMO_CYC (TMO_CYC)
  ) u_fill_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clr),
    .enable  (timer_en),
    .expire  (timer_exp)
  );

  assign shot_inc = shot_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    latch_cfg   = 1'b0;
    set_full    = 1'b0;
    toggle_bank = 1'b0;
    set_tmo     = 1'b0;
    start_dma   = 1'b0;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;
    set_mask    = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_start && cfg_enable && (cfg_nshots != '0)) begin
          latch_cfg = 1'b1;
          state_d   = S_TRIG;
        end
      end
      S_TRIG: begin
        timer_clr = 1'b1;
        state_d   = cmd_abort ? S_IDLE : S_FILL;
      end
      S_FILL: begin
        timer_en = 1'b1;
        if (cmd_abort) begin
          state_d = S_IDLE;
        end else if (fifo_usdw >= thr_q) begin
          state_d = S_XREQ;
        end else if (timer_exp) begin
          // Partial data is still worth handing over; an empty FIFO just ends the run.
          set_tmo = 1'b1;
          state_d = (fifo_usdw != '0) ? S_XREQ : S_IDLE;
        end
      end
      S_XREQ: begin
        if (cmd_abort) begin
          state_d = S_IDLE;
        end else if (!dma_busy) begin
          start_dma = 1'b1;
          state_d   = S_XFER;
        end
      end
      S_XFER: begin
        // The DMA cannot be stopped, so an abort only takes effect once it completes.
        if (dma_ready) begin
          state_d = (abort_pend_q || cmd_abort) ? S_IDLE : S_DONE;
        end
      end
      S_DONE: begin
        set_full = 1'b1;
        set_mask[bank_sel_q] = 1'b1;
        if (shot_inc == nshots_q) begin
          state_d = S_IDLE;
        end else if (!bank_full_q[~bank_sel_q]) begin
          toggle_bank = 1'b1;
          state_d     = S_TRIG;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cmd_abort) begin
          state_d = S_IDLE;
        end else if (!bank_full_q[~bank_sel_q]) begin
          toggle_bank = 1'b1;
          state_d     = S_TRIG;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      nshots_q     <= '0;
      thr_q        <= '0;
      shot_cnt_q   <= '0;
      bank_full_q  <= '0;
      bank_sel_q   <= 1'b0;
      timeout_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      laser_trig_q <= 1'b0;
      capture_en_q <= 1'b0;
      dma_start_q  <= 1'b0;
      run_busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_cfg) begin
        nshots_q   <= cfg_nshots;
        thr_q      <= cfg_threshold;
        shot_cnt_q <= '0;
      end else if (set_full) begin
        shot_cnt_q <= shot_inc;
      end
      if (latch_cfg) begin
        timeout_q <= 1'b0;
      end else if (set_tmo) begin
        timeout_q <= 1'b1;
      end
      // A set in the same cycle as a release of that bank must win.
      bank_full_q <= (bank_full_q & ~bank_release) | set_mask;
      if (toggle_bank) begin
        bank_sel_q <= ~bank_sel_q;
      end
      abort_pend_q <= (state_q == S_XFER) && !dma_ready && (abort_pend_q || cmd_abort);
      laser_trig_q <= (state_d == S_TRIG);
      capture_en_q <= (state_d == S_TRIG) || (state_d == S_FILL);
      dma_start_q  <= start_dma;
      run_busy_q   <= (state_d != S_IDLE);
    end
  end

  assign dma_start    = dma_start_q;
  assign laser_trig   = laser_trig_q;
  assign capture_en   = capture_en_q;
  assign bank_sel     = bank_sel_q;
  assign bank_full    = bank_full_q;
  assign shot_cnt     = shot_cnt_q;
  assign run_busy     = run_busy_q;
  assign timeout_flag = timeout_q;
  assign irq          = (|bank_full_q) | timeout_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Scenario bench for acq_sequencer with a queue of expected DMA target banks.
module tb_acq_sequencer;

  localparam int LVL_W   = 8;
  localparam int TMO_W   = 16;
  localparam int TMO_CYC = 100;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cfg_enable;
  logic [LVL_W-1:0] cfg_threshold;
  logic [LVL_W-1:0] cfg_nshots;
  logic             cmd_start;
  logic             cmd_abort;
  logic [1:0]       bank_release;
  logic [LVL_W-1:0] fifo_usdw;
  logic             dma_busy;
  logic             dma_ready;
  logic             dma_start;
  logic             laser_trig;
  logic             capture_en;
  logic             bank_sel;
  logic [1:0]       bank_full;
  logic [LVL_W-1:0] shot_cnt;
  logic             run_busy;
  logic             timeout_flag;
  logic             irq;

  int errors = 0;
  int checks = 0;
  int trig_count = 0;
  int dma_count = 0;
  int exp_bank[$];

  acq_sequencer #(
    .LVL_W   (LVL_W),
    .TMO_W   (TMO_W),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg_enable    (cfg_enable),
    .cfg_threshold (cfg_threshold),
    .cfg_nshots    (cfg_nshots),
    .cmd_start     (cmd_start),
    .cmd_abort     (cmd_abort),
    .bank_release  (bank_release),
    .fifo_usdw     (fifo_usdw),
    .dma_busy      (dma_busy),
    .dma_ready     (dma_ready),
    .dma_start     (dma_start),
    .laser_trig    (laser_trig),
    .capture_en    (capture_en),
    .bank_sel      (bank_sel),
    .bank_full     (bank_full),
    .shot_cnt      (shot_cnt),
    .run_busy      (run_busy),
    .timeout_flag  (timeout_flag),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (laser_trig === 1'b1) trig_count++;
    if (dma_start === 1'b1) dma_count++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [LVL_W-1:0] n, input logic [LVL_W-1:0] thr);
    cfg_nshots    = n;
    cfg_threshold = thr;
    cmd_start     = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic wait_capture(output bit got);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (capture_en === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_dma(output bit got);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (dma_start === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // DMA model: busy for three cycles, then a one-cycle ready pulse, then the DONE cycle.
  task automatic dma_serve();
    dma_busy = 1'b1;
    tick(); tick(); tick();
    dma_busy = 1'b0;
    tick();
    dma_ready = 1'b1;
    tick();
    dma_ready = 1'b0;
    tick();
  endtask

  task automatic do_shot(input logic [LVL_W-1:0] thr, output bit ok, output logic bs);
    bit g1, g2;
    ok = 1'b0;
    bs = 1'b0;
    wait_capture(g1);
    if (!g1) return;
    fifo_usdw = thr;
    wait_dma(g2);
    fifo_usdw = '0;
    if (!g2) return;
    bs = bank_sel;
    dma_serve();
    ok = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cfg_enable = 1'b1; cfg_threshold = '0; cfg_nshots = '0;
    cmd_start = 1'b0; cmd_abort = 1'b0; bank_release = '0; fifo_usdw = '0;
    dma_busy = 1'b0; dma_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({laser_trig, capture_en, dma_start, bank_sel, run_busy, timeout_flag, irq} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {laser_trig, capture_en, dma_start, bank_sel, run_busy, timeout_flag, irq});
    end
    checks++;
    if (bank_full !== 2'b00) begin errors++; $display("FAIL reset_bank_full: got %b expected 00", bank_full); end
    checks++;
    if (shot_cnt !== 8'd0) begin errors++; $display("FAIL reset_shot_cnt: got %0d expected 0", shot_cnt); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_idle_guards();
    int t0;
    t0 = trig_count;
    pulse_start(8'd0, 8'd16);
    tick();
    checks++;
    if (run_busy !== 1'b0) begin errors++; $display("FAIL nshots0_busy: got %b expected 0", run_busy); end
    cfg_enable = 1'b0;
    pulse_start(8'd1, 8'd16);
    cfg_enable = 1'b1;
    checks++;
    if (run_busy !== 1'b0) begin errors++; $display("FAIL disabled_busy: got %b expected 0", run_busy); end
    checks++;
    if (trig_count - t0 !== 0) begin errors++; $display("FAIL idle_trigs: got %0d expected 0", trig_count - t0); end
  endtask

  task automatic test_single_shot();
    int t0, d0, exp;
    t0 = trig_count; d0 = dma_count;
    exp_bank.push_back(0);
    pulse_start(8'd1, 8'd16);
    checks++;
    if ({laser_trig, capture_en, run_busy} !== 3'b111) begin
      errors++; $display("FAIL single_trig_state: got %b expected 111", {laser_trig, capture_en, run_busy});
    end
    for (int v = 0; v <= 16; v++) begin
      fifo_usdw = LVL_W'(v);
      tick();
    end
    checks++;
    if ({capture_en, dma_start} !== 2'b00) begin
      errors++; $display("FAIL single_xreq: got %b expected 00", {capture_en, dma_start});
    end
    tick();
    checks++;
    if (dma_start !== 1'b1) begin errors++; $display("FAIL single_dma_start: got %b expected 1", dma_start); end
    exp = exp_bank.pop_front();
    checks++;
    if (bank_sel !== exp[0]) begin errors++; $display("FAIL single_bank: got %b expected %b", bank_sel, exp[0]); end
    fifo_usdw = '0;
    dma_serve();
    checks++;
    if ({bank_full, irq, run_busy} !== 4'b0110) begin
      errors++; $display("FAIL single_done: got %b expected 0110", {bank_full, irq, run_busy});
    end
    checks++;
    if (shot_cnt !== 8'd1) begin errors++; $display("FAIL single_shot_cnt: got %0d expected 1", shot_cnt); end
    checks++;
    if ((trig_count - t0 !== 1) || (dma_count - d0 !== 1)) begin
      errors++; $display("FAIL single_pulses: got trig=%0d dma=%0d expected 1 1", trig_count - t0, dma_count - d0);
    end
    bank_release = 2'b01;
    tick();
    bank_release = 2'b00;
    checks++;
    if ({bank_full, irq} !== 3'b000) begin errors++; $display("FAIL single_release: got %b expected 000", {bank_full, irq}); end
  endtask

  task automatic test_release_each();
    int t0, exp;
    bit ok;
    logic bs;
    t0 = trig_count;
    exp_bank.push_back(0); exp_bank.push_back(1); exp_bank.push_back(0);
    pulse_start(8'd3, 8'd4);
    for (int s = 0; s < 3; s++) begin
      do_shot(8'd4, ok, bs);
      exp = exp_bank.pop_front();
      checks++;
      if (!ok || bs !== exp[0]) begin
        errors++; $display("FAIL rel_shot%0d_bank: got ok=%0d bank=%b expected ok=1 bank=%b", s, ok, bs, exp[0]);
      end
      checks++;
      if (run_busy !== (s < 2) || irq !== 1'b1) begin
        errors++; $display("FAIL rel_shot%0d_busy_irq: got %b%b expected %b1", s, run_busy, irq, (s < 2));
      end
      bank_release = bs ? 2'b10 : 2'b01;
      tick();
      bank_release = 2'b00;
    end
    checks++;
    if (shot_cnt !== 8'd3) begin errors++; $display("FAIL rel_shot_cnt: got %0d expected 3", shot_cnt); end
    checks++;
    if (trig_count - t0 !== 3) begin errors++; $display("FAIL rel_trigs: got %0d expected 3", trig_count - t0); end
    checks++;
    if ({bank_full, bank_sel} !== 3'b000) begin
      errors++; $display("FAIL rel_final: got %b expected 000", {bank_full, bank_sel});
    end
  endtask

  task automatic test_no_release();
    int t0, exp;
    bit ok;
    logic bs;
    t0 = trig_count;
    exp_bank.push_back(0); exp_bank.push_back(1); exp_bank.push_back(0);
    pulse_start(8'd3, 8'd4);
    for (int s = 0; s < 2; s++) begin
      do_shot(8'd4, ok, bs);
      exp = exp_bank.pop_front();
      checks++;
      if (!ok || bs !== exp[0]) begin
        errors++; $display("FAIL norel_shot%0d_bank: got ok=%0d bank=%b expected ok=1 bank=%b", s, ok, bs, exp[0]);
      end
    end
    checks++;
    if ({bank_full, capture_en, run_busy} !== 4'b1101) begin
      errors++; $display("FAIL norel_wait: got %b expected 1101", {bank_full, capture_en, run_busy});
    end
    repeat (20) tick();
    checks++;
    if (trig_count - t0 !== 2 || capture_en !== 1'b0) begin
      errors++; $display("FAIL norel_stall: got trigs=%0d cap=%b expected 2 0", trig_count - t0, capture_en);
    end
    bank_release = 2'b01;
    tick();
    bank_release = 2'b00;
    tick();
    checks++;
    if ({laser_trig, bank_sel} !== 2'b10) begin
      errors++; $display("FAIL norel_resume: got %b expected 10", {laser_trig, bank_sel});
    end
    do_shot(8'd4, ok, bs);
    exp = exp_bank.pop_front();
    checks++;
    if (!ok || bs !== exp[0]) begin
      errors++; $display("FAIL norel_shot2_bank: got ok=%0d bank=%b expected ok=1 bank=%b", ok, bs, exp[0]);
    end
    checks++;
    if ({bank_full, run_busy} !== 3'b110 || shot_cnt !== 8'd3) begin
      errors++; $display("FAIL norel_end: got %b cnt=%0d expected 110 cnt=3", {bank_full, run_busy}, shot_cnt);
    end
    bank_release = 2'b11;
    tick();
    bank_release = 2'b00;
  endtask

  task automatic test_timeout();
    int d0, exp;
    exp_bank.push_back(0);
    pulse_start(8'd1, 8'd16);
    fifo_usdw = 8'd5;
    repeat (100) tick();
    checks++;
    if ({capture_en, timeout_flag} !== 2'b10) begin
      errors++; $display("FAIL tmo_before: got %b expected 10", {capture_en, timeout_flag});
    end
    tick();
    checks++;
    if ({capture_en, timeout_flag, irq} !== 3'b011) begin
      errors++; $display("FAIL tmo_expire: got %b expected 011", {capture_en, timeout_flag, irq});
    end
    tick();
    exp = exp_bank.pop_front();
    checks++;
    if (dma_start !== 1'b1 || bank_sel !== exp[0]) begin
      errors++; $display("FAIL tmo_dma: got start=%b bank=%b expected 1 %b", dma_start, bank_sel, exp[0]);
    end
    fifo_usdw = '0;
    dma_serve();
    bank_release = 2'b01;
    tick();
    bank_release = 2'b00;
    checks++;
    if ({bank_full, irq} !== 3'b001) begin
      errors++; $display("FAIL tmo_sticky: got %b expected 001", {bank_full, irq});
    end

    exp_bank.push_back(0);
    pulse_start(8'd1, 8'd16);
    checks++;
    if (timeout_flag !== 1'b0) begin errors++; $display("FAIL tmo_cleared: got %b expected 0", timeout_flag); end
    fifo_usdw = 8'd5;
    repeat (100) tick();
    fifo_usdw = 8'd16;
    tick();
    checks++;
    if ({capture_en, timeout_flag} !== 2'b00) begin
      errors++; $display("FAIL tmo_level_wins: got %b expected 00", {capture_en, timeout_flag});
    end
    tick();
    exp = exp_bank.pop_front();
    checks++;
    if (dma_start !== 1'b1 || bank_sel !== exp[0]) begin
      errors++; $display("FAIL tmo_level_dma: got start=%b bank=%b expected 1 %b", dma_start, bank_sel, exp[0]);
    end
    fifo_usdw = '0;
    dma_serve();
    bank_release = 2'b01;
    tick();
    bank_release = 2'b00;

    d0 = dma_count;
    pulse_start(8'd1, 8'd16);
    repeat (101) tick();
    checks++;
    if ({run_busy, timeout_flag, bank_full} !== 4'b0100 || dma_count - d0 !== 0) begin
      errors++; $display("FAIL tmo_empty: got %b dma=%0d expected 0100 dma=0",
                         {run_busy, timeout_flag, bank_full}, dma_count - d0);
    end
  endtask

  task automatic test_abort();
    int t0, d0;
    bit g;
    pulse_start(8'd2, 8'd16);
    checks++;
    if ({timeout_flag, irq} !== 2'b00) begin
      errors++; $display("FAIL abort_flag_clr: got %b expected 00", {timeout_flag, irq});
    end
    tick();
    fifo_usdw = 8'd3;
    t0 = trig_count; d0 = dma_count;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    checks++;
    if ({laser_trig, capture_en} !== 2'b01) begin
      errors++; $display("FAIL busy_start_ignored: got %b expected 01", {laser_trig, capture_en});
    end
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    checks++;
    if ({capture_en, run_busy} !== 2'b00) begin
      errors++; $display("FAIL abort_fill: got %b expected 00", {capture_en, run_busy});
    end
    repeat (5) tick();
    fifo_usdw = '0;
    checks++;
    if (dma_count - d0 !== 0 || trig_count - t0 !== 0) begin
      errors++; $display("FAIL abort_fill_quiet: got dma=%0d trig=%0d expected 0 0", dma_count - d0, trig_count - t0);
    end

    d0 = dma_count;
    pulse_start(8'd1, 8'd4);
    fifo_usdw = 8'd4;
    dma_busy = 1'b1;
    tick(); tick(); tick();
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    dma_busy = 1'b0;
    fifo_usdw = '0;
    repeat (3) tick();
    checks++;
    if (run_busy !== 1'b0 || dma_count - d0 !== 0) begin
      errors++; $display("FAIL abort_xreq: got busy=%b dma=%0d expected 0 0", run_busy, dma_count - d0);
    end

    pulse_start(8'd1, 8'd4);
    fifo_usdw = 8'd4;
    wait_dma(g);
    fifo_usdw = '0;
    checks++;
    if (!g) begin errors++; $display("FAIL abort_xfer_dma: got no dma_start expected dma_start"); end
    dma_busy = 1'b1;
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    tick(); tick();
    checks++;
    if (run_busy !== 1'b1) begin errors++; $display("FAIL abort_xfer_hold: got %b expected 1", run_busy); end
    dma_busy = 1'b0;
    tick();
    dma_ready = 1'b1;
    tick();
    dma_ready = 1'b0;
    checks++;
    if (run_busy !== 1'b0) begin errors++; $display("FAIL abort_xfer_idle: got %b expected 0", run_busy); end
    tick();
    checks++;
    if ({bank_full, irq, bank_sel} !== 4'b0000 || shot_cnt !== 8'd0) begin
      errors++; $display("FAIL abort_xfer_nofull: got %b cnt=%0d expected 0000 cnt=0",
                         {bank_full, irq, bank_sel}, shot_cnt);
    end
  endtask

  task automatic test_reset_mid_xfer();
    bit ok, g;
    logic bs;
    int exp;
    exp_bank.push_back(0);
    pulse_start(8'd2, 8'd4);
    do_shot(8'd4, ok, bs);
    exp = exp_bank.pop_front();
    checks++;
    if (!ok || bs !== exp[0]) begin
      errors++; $display("FAIL rst_shot0_bank: got ok=%0d bank=%b expected ok=1 bank=%b", ok, bs, exp[0]);
    end
    wait_capture(g);
    fifo_usdw = 8'd4;
    wait_dma(g);
    fifo_usdw = '0;
    dma_busy = 1'b1;
    tick();
    checks++;
    if ({run_busy, bank_sel, bank_full, irq} !== 5'b11011) begin
      errors++; $display("FAIL rst_pre: got %b expected 11011", {run_busy, bank_sel, bank_full, irq});
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({laser_trig, capture_en, dma_start, bank_sel, bank_full, run_busy, timeout_flag, irq} !== 9'b0 ||
        shot_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_async: got %b cnt=%0d expected 000000000 cnt=0",
                         {laser_trig, capture_en, dma_start, bank_sel, bank_full, run_busy, timeout_flag, irq},
                         shot_cnt);
    end
    dma_busy = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (run_busy !== 1'b0) begin errors++; $display("FAIL rst_after: got %b expected 0", run_busy); end
  endtask

  initial begin
    test_reset();
    test_idle_guards();
    test_single_shot();
    test_release_each();
    test_no_release();
    test_timeout();
    test_abort();
    test_reset_mid_xfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
